// File: rtl/uart_rx_fifo.sv
// Receive-side event buffer for a UART receiver: queues characters, breaks and
// errors with per-entry status flags in a first-word-fall-through FIFO.
module uart_rx_fifo #(
    parameter int DataBits = 8,
    parameter int Depth    = 16,
    localparam int L       = $clog2(Depth + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DataBits-1:0] rx_data,
    input  logic                rx_valid,
    input  logic                rx_break,
    input  logic                rx_error,
    output logic [DataBits-1:0] out_data,
    output logic [1:0]          out_flags,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [L-1:0]        level,
    output logic                overrun,
    input  logic                overrun_clear
);

    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int EW = DataBits + 2;

    if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
        $error("uart_rx_fifo: DataBits must be in [5,9]");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: Depth must be a power of two >= 2");
    end

    logic [EW-1:0] mem [Depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [L-1:0]  count;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          accept;

    assign push  = rx_valid | rx_break | rx_error;
    assign full  = (count == L'(Depth));
    assign empty = (count == '0);
    assign pop   = !empty && out_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign accept = push && (!full || pop);

    always_comb begin
        entry = '0;
        if (rx_valid) begin
            entry = {2'b00, rx_data};
        end else if (rx_break) begin
            entry = {2'b10, {DataBits{1'b0}}};
        end else if (rx_error) begin
            entry = {2'b01, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + L'(1);
                2'b01:   count <= count - L'(1);
                default: count <= count;
            endcase
            // A dropped push outranks a concurrent clear.
            if (push && !accept) begin
                overrun <= 1'b1;
            end else if (overrun_clear) begin
                overrun <= 1'b0;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : head[DataBits-1:0];
    assign out_flags = empty ? 2'b00 : head[EW-1:DataBits];
    assign level     = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo: a queue-based reference model
// predicts accepted entries, fill level and overrun; a monitor checks each pop.
module tb_uart_rx_fifo;

    localparam int DataBits = 8;
    localparam int Depth    = 16;
    localparam int L        = $clog2(Depth + 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [DataBits-1:0] rx_data = '0;
    logic                rx_valid = 1'b0;
    logic                rx_break = 1'b0;
    logic                rx_error = 1'b0;
    logic [DataBits-1:0] out_data;
    logic [1:0]          out_flags;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [L-1:0]        level;
    logic                overrun;
    logic                overrun_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DataBits+1:0] sb[$];
    int                  m_level = 0;
    bit                  m_ovr = 1'b0;

    uart_rx_fifo #(.DataBits(DataBits), .Depth(Depth)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_break(rx_break),
        .rx_error(rx_error),
        .out_data(out_data),
        .out_flags(out_flags),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .level(level),
        .overrun(overrun),
        .overrun_clear(overrun_clear)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [DataBits+1:0] expectEntry(input bit v, input bit b, input bit e,
                                                        input logic [DataBits-1:0] d);
        if (v) return {2'b00, d};
        if (b) return {2'b10, {DataBits{1'b0}}};
        if (e) return {2'b01, d};
        return '0;
    endfunction

    // Monitor: a pop happens on the coming rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                compare("pop_with_empty_scoreboard", 1, 0);
            end else begin
                compare("pop_entry", int'({out_flags, out_data}), int'(sb.pop_front()));
            end
        end else if (!out_valid) begin
            compare("empty_outputs_zero", int'({out_flags, out_data}), 0);
        end
    end

    task automatic checkOutput();
        compare("level", int'(level), m_level);
        compare("out_valid", int'(out_valid), int'(m_level > 0));
        compare("overrun", int'(overrun), int'(m_ovr));
        if (sb.size() > 0) begin
            compare("head_entry", int'({out_flags, out_data}), int'(sb[0]));
        end
    endtask

    task automatic applyStimulus(input bit v, input bit b, input bit e,
                                 input logic [DataBits-1:0] d, input bit rdy, input bit clr);
        bit push;
        bit pop;
        bit accept;
        checkOutput();
        rx_valid      = v;
        rx_break      = b;
        rx_error      = e;
        rx_data       = d;
        out_ready     = rdy;
        overrun_clear = clr;
        push   = v | b | e;
        pop    = (m_level > 0) && rdy;
        accept = push && ((m_level < Depth) || pop);
        if (accept) sb.push_back(expectEntry(v, b, e, d));
        m_level = m_level + int'(accept) - int'(pop);
        if (push && !accept) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * Depth && m_level > 0; i++) idle(1'b1);
        compare("drained", m_level, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput();

        // Ordering with the consumer stalled, then draining.
        applyStimulus(1, 0, 0, 8'h10, 0, 0);
        applyStimulus(1, 0, 0, 8'h20, 0, 0);
        applyStimulus(1, 0, 0, 8'h30, 0, 0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        checkOutput();

        // Flag encoding and strobe priority.
        applyStimulus(0, 1, 0, 8'hFF, 0, 0);
        applyStimulus(0, 0, 1, 8'h55, 0, 0);
        applyStimulus(1, 0, 0, 8'h7E, 0, 0);
        applyStimulus(1, 0, 1, 8'h11, 0, 0);
        applyStimulus(1, 1, 1, 8'h22, 0, 0);
        drain();

        // Fill past full, then exercise the overrun clear and set-wins rule.
        for (int i = 0; i < Depth + 1; i++) applyStimulus(1, 0, 0, 8'($urandom), 0, 0);
        applyStimulus(0, 0, 0, '0, 0, 1);
        applyStimulus(0, 0, 1, 8'h33, 0, 1);
        applyStimulus(0, 0, 0, '0, 0, 1);
        // Push into a full FIFO while popping.
        applyStimulus(1, 0, 0, 8'hAA, 1, 0);
        checkOutput();
        drain();

        // Reset in the middle of traffic with entries queued.
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 8'(8'hC0 + i), 0, 0);
        idle(1'b0);
        rst_n = 1'b0;
        sb.delete();
        m_level = 0;
        m_ovr   = 1'b0;
        #1;
        compare("reset_level", int'(level), 0);
        compare("reset_out_valid", int'(out_valid), 0);
        compare("reset_out_data", int'(out_data), 0);
        compare("reset_overrun", int'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 0, 8'h41, 0, 0);
        checkOutput();
        drain();

        // Random traffic: push-heavy phase reaches full, balanced phase exercises wrap.
        for (int i = 0; i < 300; i++) begin
            bit heavy;
            heavy = (i < 120);
            applyStimulus(bit'($urandom_range(0, heavy ? 1 : 3) == 0) | heavy & bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 9) == 0),
                          bit'($urandom_range(0, 7) == 0),
                          8'($urandom),
                          bit'($urandom_range(0, heavy ? 3 : 1) == 0),
                          bit'($urandom_range(0, 15) == 0));
        end
        drain();
        checkOutput();
        compare("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
